// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - immediate-format type and unified memory port handshake for multicycle_ctrl
// master: controller side (drives mem_req, mem_write, adr_src; samples mem_ready)
// slave : memory side (samples mem_req, mem_write, adr_src; drives mem_ready)

package multicycle_ctrl_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } immsrc_e;
endpackage

interface multicycle_ctrl_if;
  logic mem_req;    // access request, held until mem_ready
  logic mem_write;  // access is a store
  logic adr_src;    // 0: PC, 1: ALUOut as address
  logic mem_ready;  // memory completes the current access this cycle

  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multicycle RV32I core
// Ports:
//   clk, rst_n      core clock, asynchronous active-low reset
//   start           leave HALT (RESET_TO_FETCH=0 only)
//   op, funct3      instruction fields from the instruction register
//   zero            ALU zero flag of the current cycle
//   mem             memory handshake (multicycle_ctrl_if.master)
//   ir_write        load instruction register + OldPC
//   pc_write        update PC from Result
//   reg_write       register file write enable
//   imm_src         immediate format for the extractor
//   alu_src_a/b     ALU operand selects
//   alu_op          00 add, 01 sub, 10 decode funct fields
//   result_src      00 ALUOut, 01 mem data, 10 ALUResult
//   illegal         sticky unsupported-opcode flag

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit RESET_TO_FETCH = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  multicycle_ctrl_if.master    mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output immsrc_e              imm_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic                 illegal
);

  typedef enum logic [3:0] {
    S_HALT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam state_t RESET_STATE = RESET_TO_FETCH ? S_FETCH : S_HALT;

  state_t     state, nxt;
  logic       mem_req_q, mem_write_q, adr_src_q, pc_write_q, reg_write_q;
  logic       n_mem_req, n_mem_write, n_adr_src, n_pc_write, n_reg_write;
  immsrc_e    n_imm_src;
  logic [1:0] n_src_a, n_src_b, n_alu_op, n_result_src;
  logic       fetch_fire, branch_take;

  // A fetch completes only while the request is actually out; right after
  // reset the FETCH state holds mem_req low for one cycle.
  assign fetch_fire  = (state == S_FETCH) && mem_req_q && mem.mem_ready;
  assign branch_take = (state == S_BRANCH) &&
                       (((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero));

  always_comb begin
    nxt = state;
    case (state)
      S_HALT:     if (start) nxt = S_FETCH;
      S_FETCH:    if (mem_req_q && mem.mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: nxt = S_MEMADR;
          OP_R:              nxt = S_EXECR;
          OP_I:              nxt = S_EXECI;
          OP_JAL:            nxt = S_JAL;
          OP_BRANCH:         nxt = S_BRANCH;
          OP_LUI:            nxt = S_LUI;
          default:           nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem.mem_ready) nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: if (mem.mem_ready) nxt = S_FETCH;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_BRANCH:   nxt = ((funct3 == 3'b000) || (funct3 == 3'b001)) ? S_FETCH : S_TRAP;
      S_LUI:      nxt = S_ALUWB;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_TRAP;
    endcase
  end

  // Moore outputs decoded from the state being entered, so they come out of flops.
  always_comb begin
    n_mem_req    = 1'b0;
    n_mem_write  = 1'b0;
    n_adr_src    = 1'b0;
    n_pc_write   = 1'b0;
    n_reg_write  = 1'b0;
    n_imm_src    = IMM_I;
    n_src_a      = 2'b00;
    n_src_b      = 2'b00;
    n_alu_op     = 2'b00;
    n_result_src = 2'b00;
    case (nxt)
      S_FETCH: begin
        n_mem_req    = 1'b1;
        n_src_b      = 2'b10;
        n_result_src = 2'b10;
      end
      S_DECODE: begin
        n_src_a   = 2'b01;
        n_src_b   = 2'b01;
        n_imm_src = IMM_B;
      end
      S_MEMADR: begin
        n_src_a   = 2'b10;
        n_src_b   = 2'b01;
        n_imm_src = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        n_mem_req = 1'b1;
        n_adr_src = 1'b1;
      end
      S_MEMWB: begin
        n_result_src = 2'b01;
        n_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        n_mem_req   = 1'b1;
        n_mem_write = 1'b1;
        n_adr_src   = 1'b1;
      end
      S_EXECR: begin
        n_src_a  = 2'b10;
        n_alu_op = 2'b10;
      end
      S_EXECI: begin
        n_src_a  = 2'b10;
        n_src_b  = 2'b01;
        n_alu_op = 2'b10;
      end
      S_ALUWB:  n_reg_write = 1'b1;
      S_JAL: begin
        n_src_a    = 2'b01;
        n_src_b    = 2'b10;
        n_pc_write = 1'b1;
        n_imm_src  = IMM_J;
      end
      S_BRANCH: begin
        n_src_a  = 2'b10;
        n_alu_op = 2'b01;
      end
      S_LUI: begin
        n_src_a   = 2'b10;  // datapath forces rs1 to x0
        n_src_b   = 2'b01;
        n_imm_src = IMM_U;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_STATE;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      adr_src_q   <= 1'b0;
      pc_write_q  <= 1'b0;
      reg_write_q <= 1'b0;
      imm_src     <= IMM_I;
      alu_src_a   <= 2'b00;
      alu_src_b   <= 2'b00;
      alu_op      <= 2'b00;
      result_src  <= 2'b00;
      illegal     <= 1'b0;
    end else begin
      state       <= nxt;
      mem_req_q   <= n_mem_req;
      mem_write_q <= n_mem_write;
      adr_src_q   <= n_adr_src;
      pc_write_q  <= n_pc_write;
      reg_write_q <= n_reg_write;
      imm_src     <= n_imm_src;
      alu_src_a   <= n_src_a;
      alu_src_b   <= n_src_b;
      alu_op      <= n_alu_op;
      result_src  <= n_result_src;
      illegal     <= illegal | (nxt == S_TRAP);
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_write = mem_write_q;
  assign mem.adr_src   = adr_src_q;
  assign ir_write      = fetch_fire;
  assign pc_write      = pc_write_q | fetch_fire | branch_take;
  assign reg_write     = reg_write_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl

module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum {
    T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECR, T_EXECI, T_ALUWB, T_JAL, T_BRANCH, T_LUI, T_TRAP
  } tst_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [2:0] imm;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] alu;
    logic [1:0] res;
    logic       illegal;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic zero = 1'b0;
  logic ir_write, pc_write, reg_write, illegal;
  immsrc_e imm_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;

  multicycle_ctrl_if mem_if ();

  multicycle_ctrl #(.RESET_TO_FETCH(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .funct3     (funct3),
    .zero       (zero),
    .mem        (mem_if.master),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .imm_src    (imm_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ir_cnt, reg_cnt, cyc_cnt;
  outs_t exp_q[$];

  function automatic outs_t actual();
    return {mem_if.mem_req, mem_if.mem_write, mem_if.adr_src, ir_write, pc_write, reg_write,
            imm_src, alu_src_a, alu_src_b, alu_op, result_src, illegal};
  endfunction

  function automatic outs_t exp_out(tst_t st, logic rdy);
    outs_t e = '0;
    case (st)
      T_FETCH:    begin e.mem_req = 1; e.ir_write = rdy; e.pc_write = rdy; e.b = 2; e.res = 2; end
      T_DECODE:   begin e.a = 1; e.b = 1; e.imm = 3'd2; end
      T_MEMADR:   begin e.a = 2; e.b = 1; e.imm = (op == OP_STORE) ? 3'd1 : 3'd0; end
      T_MEMREAD:  begin e.mem_req = 1; e.adr_src = 1; end
      T_MEMWB:    begin e.res = 1; e.reg_write = 1; end
      T_MEMWRITE: begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; end
      T_EXECR:    begin e.a = 2; e.alu = 2; end
      T_EXECI:    begin e.a = 2; e.b = 1; e.alu = 2; end
      T_ALUWB:    e.reg_write = 1;
      T_JAL:      begin e.a = 1; e.b = 2; e.pc_write = 1; e.imm = 3'd3; end
      T_BRANCH: begin
        e.a = 2; e.alu = 1;
        e.pc_write = (funct3 == 3'b000) ? zero : (funct3 == 3'b001) ? ~zero : 1'b0;
      end
      T_LUI:      begin e.a = 2; e.b = 1; e.imm = 3'd4; end
      T_TRAP:     e.illegal = 1;
      default: ;
    endcase
    return e;
  endfunction

  // One clock cycle: called at posedge+1, drives mem_ready, samples at negedge.
  task automatic cyc(input tst_t st, input logic rdy);
    outs_t e, a;
    mem_if.mem_ready = rdy;
    exp_q.push_back(exp_out(st, rdy));
    @(negedge clk);
    a = actual();
    e = exp_q.pop_front();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL cycle %s op=%b f3=%b: got=%h want=%h", st.name(), op, funct3, a, e);
    end
    ir_cnt += int'(ir_write);
    reg_cnt += int'(reg_write);
    cyc_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_if.mem_ready = 1'b0;
    #1;
    checks++;
    if (actual() !== outs_t'(0)) begin
      failures++;
      $display("FAIL reset_outputs: got=%h want=%h", actual(), outs_t'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                           input int fw, input int mw);
    op = o; funct3 = f3; zero = z;
    ir_cnt = 0; reg_cnt = 0; cyc_cnt = 0;
    repeat (fw) cyc(T_FETCH, 1'b0);
    cyc(T_FETCH, 1'b1);
    cyc(T_DECODE, 1'b1);
    case (o)
      OP_LOAD: begin
        cyc(T_MEMADR, 1'b1);
        repeat (mw) cyc(T_MEMREAD, 1'b0);
        cyc(T_MEMREAD, 1'b1);
        cyc(T_MEMWB, 1'b1);
      end
      OP_STORE: begin
        cyc(T_MEMADR, 1'b1);
        repeat (mw) cyc(T_MEMWRITE, 1'b0);
        cyc(T_MEMWRITE, 1'b1);
      end
      OP_R:   begin cyc(T_EXECR, 1'b1); cyc(T_ALUWB, 1'b1); end
      OP_I:   begin cyc(T_EXECI, 1'b1); cyc(T_ALUWB, 1'b1); end
      OP_JAL: begin cyc(T_JAL, 1'b1);   cyc(T_ALUWB, 1'b1); end
      OP_LUI: begin cyc(T_LUI, 1'b1);   cyc(T_ALUWB, 1'b1); end
      OP_BRANCH: begin
        cyc(T_BRANCH, 1'b1);
        if (f3 != 3'b000 && f3 != 3'b001) repeat (3) cyc(T_TRAP, 1'b1);
      end
      default: repeat (3) cyc(T_TRAP, 1'b1);
    endcase
  endtask

  task automatic test_reset();
    do_reset();
    cyc(T_RST, 1'b1);
    op = OP_LOAD; funct3 = 3'b010;
    cyc(T_FETCH, 1'b1);
    cyc(T_DECODE, 1'b1);
    cyc(T_MEMADR, 1'b1);
    cyc(T_MEMREAD, 1'b0);
    rst_n = 1'b0;
    mem_if.mem_ready = 1'b1;
    #1;
    checks++;
    if (mem_if.mem_req !== 1'b0 || illegal !== 1'b0 || reg_write !== 1'b0 || pc_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_memread: mem_req=%b illegal=%b reg_write=%b pc_write=%b want 0000",
               mem_if.mem_req, illegal, reg_write, pc_write);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(T_RST, 1'b1);
  endtask

  task automatic test_add();
    run_instr(OP_R, 3'b000, 1'b0, 0, 0);
    checks++;
    if (cyc_cnt !== 4 || reg_cnt !== 1) begin
      failures++;
      $display("FAIL add_cycles: cycles=%0d reg_writes=%0d want 4 and 1", cyc_cnt, reg_cnt);
    end
  endtask

  task automatic test_lw_wait();
    run_instr(OP_LOAD, 3'b010, 1'b0, 2, 1);
    checks++;
    if (cyc_cnt !== 8 || ir_cnt !== 1) begin
      failures++;
      $display("FAIL lw_wait: cycles=%0d ir_writes=%0d want 8 and 1", cyc_cnt, ir_cnt);
    end
  endtask

  task automatic test_sw();
    run_instr(OP_STORE, 3'b010, 1'b0, 0, 2);
    checks++;
    if (reg_cnt !== 0 || cyc_cnt !== 6) begin
      failures++;
      $display("FAIL sw_no_regwrite: reg_writes=%0d cycles=%0d want 0 and 6", reg_cnt, cyc_cnt);
    end
  endtask

  task automatic test_other_ops();
    run_instr(OP_I, 3'b000, 1'b0, 1, 0);
    run_instr(OP_JAL, 3'b000, 1'b0, 0, 0);
    run_instr(OP_LUI, 3'b000, 1'b0, 0, 0);
  endtask

  task automatic test_branch();
    run_instr(OP_BRANCH, 3'b000, 1'b1, 0, 0);
    run_instr(OP_BRANCH, 3'b001, 1'b1, 0, 0);
    run_instr(OP_BRANCH, 3'b000, 1'b0, 0, 0);
    run_instr(OP_BRANCH, 3'b001, 1'b0, 0, 0);
    run_instr(OP_BRANCH, 3'b100, 1'b1, 0, 0);
    do_reset();
    cyc(T_RST, 1'b1);
  endtask

  task automatic test_illegal_op();
    run_instr(7'b0000000, 3'b000, 1'b0, 0, 0);
    do_reset();
    cyc(T_RST, 1'b1);
    run_instr(OP_R, 3'b000, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_instr(OP_LOAD, 3'b010, 1'b0, 0, 0);
    run_instr(OP_STORE, 3'b010, 1'b0, 1, 0);
    run_instr(OP_R, 3'b000, 1'b0, 0, 0);
  endtask

  initial begin
    mem_if.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_sw();
    test_other_ops();
    test_back_to_back();
    test_branch();
    test_illegal_op();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: left=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
